// File: rtl/or1200_ibarb_if.sv
// Bundle of requester, shared instruction bus and status signals for or1200_ibarb.
// slave: arbiter side; master: requesters / bus environment side.
interface or1200_ibarb_if;
    logic [31:0] f_adr_i;
    logic        f_cyc_i;
    logic        f_ack_o;
    logic        f_err_o;
    logic [31:0] d_adr_i;
    logic        d_cyc_i;
    logic        d_ack_o;
    logic        d_err_o;
    logic [31:0] b_adr_o;
    logic        b_cyc_o;
    logic [31:0] b_dat_i;
    logic        b_ack_i;
    logic        b_err_i;
    logic [3:0]  b_tag_i;
    logic [31:0] dat_o;
    logic [3:0]  tag_o;
    logic [1:0]  owner_o;

    modport slave (
        input  f_adr_i, f_cyc_i, d_adr_i, d_cyc_i,
        input  b_dat_i, b_ack_i, b_err_i, b_tag_i,
        output f_ack_o, f_err_o, d_ack_o, d_err_o,
        output b_adr_o, b_cyc_o, dat_o, tag_o, owner_o
    );

    modport master (
        output f_adr_i, f_cyc_i, d_adr_i, d_cyc_i,
        output b_dat_i, b_ack_i, b_err_i, b_tag_i,
        input  f_ack_o, f_err_o, d_ack_o, d_err_o,
        input  b_adr_o, b_cyc_o, dat_o, tag_o, owner_o
    );
endinterface

// File: rtl/or1200_ibarb.sv
// Round-robin arbiter between fetch and debug requesters on a shared instruction bus.
// Optional bus watchdog: define OR1200_IBARB_TIMEOUT_EN.
module or1200_ibarb #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic             clk,
    input  logic             rst,
    or1200_ibarb_if.slave    bus
);

    localparam int unsigned ADR_W = 32;
    localparam logic [3:0]  TAG_BE = 4'hb;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_F = 2'b01,
        OWN_D = 2'b10
    } state_t;

    state_t r_state;
    state_t w_next;
    // Set when debug holds the turn on the next tie; clear after reset so fetch wins first.
    logic   r_last_d;
    logic   w_last_d_nxt;
    logic   w_timeout;

`ifdef OR1200_IBARB_TIMEOUT_EN
    logic [7:0] r_wdog;

    // Watchdog: cleared while idle, counts owned cycles that see no ack/err.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= 8'd0;
        end else if (r_state == IDLE) begin
            r_wdog <= 8'd0;
        end else if (!(bus.b_ack_i || bus.b_err_i)) begin
            r_wdog <= r_wdog + 8'd1;
        end
    end

    assign w_timeout = (r_state != IDLE) && (r_wdog == TIMEOUT_CYCLES);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_last_d <= w_last_d_nxt;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_last_d_nxt = r_last_d;
        bus.b_cyc_o  = 1'b0;
        bus.b_adr_o  = ADR_W'(0);
        bus.f_ack_o  = 1'b0;
        bus.f_err_o  = 1'b0;
        bus.d_ack_o  = 1'b0;
        bus.d_err_o  = 1'b0;
        bus.dat_o    = bus.b_dat_i;
        bus.tag_o    = bus.b_tag_i;
        bus.owner_o  = r_state;

        unique case (r_state)
            IDLE: begin
                if (bus.f_cyc_i && bus.d_cyc_i) begin
                    if (r_last_d) begin
                        w_next       = OWN_D;
                        w_last_d_nxt = 1'b0;
                    end else begin
                        w_next       = OWN_F;
                        w_last_d_nxt = 1'b1;
                    end
                end else if (bus.f_cyc_i) begin
                    w_next       = OWN_F;
                    w_last_d_nxt = 1'b1;
                end else if (bus.d_cyc_i) begin
                    w_next       = OWN_D;
                    w_last_d_nxt = 1'b0;
                end
            end

            OWN_F: begin
                bus.b_adr_o = bus.f_adr_i & 32'hFFFF_FFFC;
                if (!bus.f_cyc_i) begin
                    w_next = IDLE;
                end else if (w_timeout) begin
                    bus.f_err_o = 1'b1;
                    bus.tag_o   = TAG_BE;
                    w_next      = IDLE;
                end else begin
                    bus.b_cyc_o = 1'b1;
                    bus.f_ack_o = bus.b_ack_i;
                    bus.f_err_o = bus.b_err_i & ~bus.b_ack_i;
                    if (bus.b_ack_i || bus.b_err_i) begin
                        w_next = IDLE;
                    end
                end
            end

            OWN_D: begin
                bus.b_adr_o = bus.d_adr_i & 32'hFFFF_FFFC;
                if (!bus.d_cyc_i) begin
                    w_next = IDLE;
                end else if (w_timeout) begin
                    bus.d_err_o = 1'b1;
                    bus.tag_o   = TAG_BE;
                    w_next      = IDLE;
                end else begin
                    bus.b_cyc_o = 1'b1;
                    bus.d_ack_o = bus.b_ack_i;
                    bus.d_err_o = bus.b_err_i & ~bus.b_ack_i;
                    if (bus.b_ack_i || bus.b_err_i) begin
                        w_next = IDLE;
                    end
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/or1200_ibarb.md
OR1200_IBARB -- requirements
Module: or1200_ibarb

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 8'd255, bus-cycle watchdog limit in clock cycles (1..255).
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: f_adr_i  input  32  fetch requester address.
REQ-005 Port: f_cyc_i  input  1  fetch requester cycle request; held until ack/err or abort.
REQ-006 Port: f_ack_o  output  1  fetch transfer complete, data valid.
REQ-007 Port: f_err_o  output  1  fetch transfer error, tag valid.
REQ-008 Port: d_adr_i  input  32  debug requester address.
REQ-009 Port: d_cyc_i  input  1  debug requester cycle request.
REQ-010 Port: d_ack_o  output  1  debug transfer complete.
REQ-011 Port: d_err_o  output  1  debug transfer error.
REQ-012 Port: b_adr_o  output  32  shared instruction bus address.
REQ-013 Port: b_cyc_o  output  1  shared bus cycle strobe.
REQ-014 Port: b_dat_i  input  32  shared bus read data.
REQ-015 Port: b_ack_i  input  1  shared bus acknowledge.
REQ-016 Port: b_err_i  input  1  shared bus error.
REQ-017 Port: b_tag_i  input  4  shared bus error tag (TE 4'hd, PE 4'hc, BE 4'hb).
REQ-018 Port: dat_o  output  32  read data to both requesters; equals b_dat_i.
REQ-019 Port: tag_o  output  4  tag to both requesters; b_tag_i, or 4'hb on timeout.
REQ-020 Port: owner_o  output  2  current owner: 2'b00 none, 2'b01 fetch, 2'b10 debug.

Function
REQ-021 FSM states IDLE, OWN_F, OWN_D; owner_o encodes state (IDLE=00, OWN_F=01, OWN_D=10).
REQ-022 IDLE: only f_cyc_i -> OWN_F next cycle; only d_cyc_i -> OWN_D next cycle; none -> stay IDLE.
REQ-023 IDLE, both requesting: grant to requester that did not win last grant (round-robin bit last_d); after reset fetch wins first tie.
REQ-024 Grant latency exactly one cycle from request in IDLE to b_cyc_o high.
REQ-025 OWN_x: b_cyc_o = owner's cyc; b_adr_o = owner's address, bits [1:0] forced 2'b00; IDLE: b_cyc_o=0, b_adr_o=32'h0.
REQ-026 OWN_x: x_ack_o = b_ack_i & x_cyc_i, x_err_o = b_err_i & x_cyc_i & !b_ack_i, combinational; non-owner ack/err always 0.
REQ-027 b_ack_i and b_err_i same cycle: ack wins, err suppressed.
REQ-028 OWN_x with ack or err: return to IDLE next cycle; last_d updated at grant time.
REQ-029 Owner drops cyc (abort, e.g. pipeline flush): b_cyc_o falls same cycle, FSM -> IDLE next cycle, no ack/err forwarded.
REQ-030 b_ack_i/b_err_i while IDLE: ignored, no requester output asserted.
REQ-031 Requester raising cyc while other owns bus: waits, no output pulse, granted after owner completes.

Reset
REQ-032 rst=1 at clk edge: FSM IDLE, last_d=0, watchdog count 0; outputs owner_o=00, b_cyc_o=0, all ack/err 0, b_adr_o=0.
REQ-033 rst mid-transaction: bus cycle dropped next cycle, pending ack lost, requesters must re-request.

Configuration
REQ-034 Macro OR1200_IBARB_TIMEOUT_EN defined: 8-bit counter clears on grant, increments each OWN_x cycle with no ack/err; at TIMEOUT_CYCLES, owner err_o=1 one cycle, tag_o=4'hb, b_cyc_o=0 that cycle, FSM -> IDLE.
REQ-035 Macro undefined: no counter, tag_o=b_tag_i always, OWN_x held indefinitely until ack/err/abort.

Verification
REQ-036 Fetch-only: f_cyc_i=1 @cycle0, f_adr_i=32'h100 -> b_cyc_o=1, b_adr_o=32'h100 @cycle1; b_ack_i @cycle3 -> f_ack_o=1, dat_o=b_dat_i, owner_o=00 @cycle4.
REQ-037 Tie: f_cyc_i=d_cyc_i=1 from reset -> fetch granted, ack, next grant debug, then fetch (alternating).
REQ-038 Error: OWN_F, b_err_i=1, b_tag_i=4'hd -> f_err_o=1, tag_o=4'hd, d_err_o=0; b_ack_i with b_err_i -> only f_ack_o.
REQ-039 Abort: OWN_D, d_cyc_i drops -> b_cyc_o=0 same cycle, owner_o=00 next; later stray b_ack_i -> no ack outputs.
REQ-040 Timeout (macro on, TIMEOUT_CYCLES=4): OWN_F, no ack for 4 cycles -> f_err_o=1, tag_o=4'hb, IDLE next; macro off -> stays OWN_F.
REQ-041 Reset mid OWN_D with d_cyc_i held -> owner_o=00 next cycle, re-grant to debug one cycle after rst release.
